// File: rtl/cd_pkg.sv
// Shared colour-detector definitions: colour codes, the clear-phase filter code,
// voter FSM state encodings and the per-window tally record.
`timescale 1ns/1ps

package cd_pkg;

    localparam logic [1:0] FILTER_CLEAR = 2'b10;

    localparam logic [2:0] COLOR_NONE  = 3'd0;
    localparam logic [2:0] COLOR_RED   = 3'd1;
    localparam logic [2:0] COLOR_GREEN = 3'd2;
    localparam logic [2:0] COLOR_BLUE  = 3'd3;

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_REPORT  = 1'b1;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } tally_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/cd_sample_strobe.sv
// Detects entry into the detector's clear phase (filter == 2'b10) and presents
// the colour code present on that same cycle as the raw sample.
`timescale 1ns/1ps

module cd_sample_strobe
    import cd_pkg::*;
(
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic [1:0] filter,
    input  logic [2:0] color,
    output logic       take,
    output logic [2:0] sample_color
);

    logic [1:0] prev_filter;

    // NOTE: resetting to the clear code means a filter already sitting at 2'b10
    // when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) prev_filter <= FILTER_CLEAR;
        else        prev_filter <= filter;
    end

    assign take         = (filter == FILTER_CLEAR) && (prev_filter != FILTER_CLEAR);
    assign sample_color = color;

endmodule

// File: rtl/cd_color_voter.sv
// Majority voter over VOTE_N raw colour detections with a valid/ready result port
// and saturating result tallies. Optional idle timeout: define CD_VOTE_TIMEOUT_EN.
`timescale 1ns/1ps

module cd_color_voter
    import cd_pkg::*;
#(
    parameter int VOTE_N      = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic [1:0] filter,
    input  logic [2:0] color,
    output logic [1:0] det_color,
    output logic       det_valid,
    input  logic       det_ready,
    output logic [7:0] red_cnt,
    output logic [7:0] green_cnt,
    output logic [7:0] blue_cnt,
    output logic       drop_flag,
    output logic       stale
);

    localparam logic [3:0] WINDOW = 4'(VOTE_N);
    localparam logic [3:0] HALF   = 4'(VOTE_N / 2);

    logic       take;
    logic [2:0] sample_color;
    logic       state;
    tally_t     tally, tally_nxt;
    logic [3:0] sample_cnt, cnt_nxt;
    logic       window_full;
    logic [2:0] winner;
    logic       handshake;
    logic       timeout_fire;

    cd_sample_strobe u_strobe (
        .clk_1MHz     (clk_1MHz),
        .rst_n        (rst_n),
        .filter       (filter),
        .color        (color),
        .take         (take),
        .sample_color (sample_color)
    );

    // Tallies as they would stand with the current sample credited; illegal and
    // "none" codes lengthen the window but favour no colour.
    always_comb begin
        tally_nxt = tally;
        case (sample_color)
            COLOR_RED:   tally_nxt.red   = tally.red   + 4'd1;
            COLOR_GREEN: tally_nxt.green = tally.green + 4'd1;
            COLOR_BLUE:  tally_nxt.blue  = tally.blue  + 4'd1;
            default:     ;
        endcase
        cnt_nxt     = sample_cnt + 4'd1;
        window_full = (cnt_nxt == WINDOW);
        if      (tally_nxt.red   > HALF) winner = COLOR_RED;
        else if (tally_nxt.green > HALF) winner = COLOR_GREEN;
        else if (tally_nxt.blue  > HALF) winner = COLOR_BLUE;
        else                             winner = COLOR_NONE;
    end

    assign handshake = det_valid && det_ready;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_COLLECT;
            tally      <= '0;
            sample_cnt <= '0;
            det_valid  <= 1'b0;
            det_color  <= 2'd0;
            red_cnt    <= 8'd0;
            green_cnt  <= 8'd0;
            blue_cnt   <= 8'd0;
            drop_flag  <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (take) begin
                        if (window_full) begin
                            tally      <= '0;
                            sample_cnt <= '0;
                            if (winner != COLOR_NONE) begin
                                det_color <= winner[1:0];
                                det_valid <= 1'b1;
                                state     <= ST_REPORT;
                            end
                        end else begin
                            tally      <= tally_nxt;
                            sample_cnt <= cnt_nxt;
                        end
                    end else if (timeout_fire) begin
                        tally      <= '0;
                        sample_cnt <= '0;
                    end
                end
                default: begin
                    // Samples are never queued behind a pending result.
                    if (take) drop_flag <= 1'b1;
                    if (handshake) begin
                        case (det_color)
                            COLOR_RED[1:0]:   red_cnt   <= sat_inc8(red_cnt);
                            COLOR_GREEN[1:0]: green_cnt <= sat_inc8(green_cnt);
                            COLOR_BLUE[1:0]:  blue_cnt  <= sat_inc8(blue_cnt);
                            default:          ;
                        endcase
                        det_valid  <= 1'b0;
                        tally      <= '0;
                        sample_cnt <= '0;
                        state      <= ST_COLLECT;
                    end
                end
            endcase
        end
    end

`ifdef CD_VOTE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_fire = (state == ST_COLLECT) && (sample_cnt != 4'd0) && !take &&
                          (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else begin
            stale <= timeout_fire;
            if (state != ST_COLLECT || take || timeout_fire || sample_cnt == 4'd0)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Timeout length is meaningless without the idle counter.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_fire       = 1'b0;
    assign stale              = 1'b0;
`endif

endmodule
